wrptr_control_ext: RTL and testbench

Write-side pointer controller for the async FIFO, successor to the fixed-width write-pointer block. It is parametrised by address width and adds:
- a registered fill level
- a runtime-programmable almost-full flag
- a sticky overflow flag with clear
- a saturating dropped-write counter

It sits in the write clock domain. It drives the memory write address and the Gray write pointer, which goes to the read-domain synchroniser. It consumes the 2-flop-synchronised Gray read pointer.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/gray2bin_conv.sv | 17 +
 rtl/wrptr_control_ext.sv | 102 ++++++++++
 tb/tb_wrptr_control_ext.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer blocks: Gray/binary conversion
// and the depth calculation, sized generically up to 32-bit pointers.
package fifo_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef logic [GRAY_MAX_W-1:0] gvec_t;

    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Caller truncates the result to its own pointer width.
    function automatic gvec_t bin2gray(input gvec_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR by doubling shifts. Bits at or above 'width' are ignored.
    function automatic gvec_t gray2bin(input gvec_t g, input int width);
        gvec_t b;
        b = g & ((gvec_t'(1) << width) - gvec_t'(1));
        for (int s = 1; s < GRAY_MAX_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Purely combinational Gray-to-binary converter; bit i is the XOR of all
// Gray bits from i up to the MSB. Shared with the read-side pointer block.
module gray2bin_conv #(
    parameter int W = 9
) (
    input  logic [W-1:0] i_gray,
    output logic [W-1:0] o_bin
);

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            assign o_bin[gi] = ^i_gray[W-1:gi];
        end
    endgenerate

endmodule

// File: rtl/wrptr_control_ext.sv
// Write-domain pointer controller for the async FIFO: binary/Gray write
// pointer, full and almost-full flags, fill level, and overflow accounting.
module wrptr_control_ext
    import fifo_pkg::*;
#(
    parameter  int ADDR_WIDTH     = 8,
    parameter  int DROP_CNT_WIDTH = 8,
    localparam int PTR_WIDTH      = ADDR_WIDTH + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      wren,
    input  logic [PTR_WIDTH-1:0]      rptr_sync2,
    input  logic [PTR_WIDTH-1:0]      af_thresh,
    input  logic                      ovf_clr,
    output logic [PTR_WIDTH-1:0]      wrptr,
    output logic [ADDR_WIDTH-1:0]     waddr,
    output logic                      wfull,
    output logic                      wafull,
    output logic [PTR_WIDTH-1:0]      wlevel,
    output logic                      woverflow,
    output logic [DROP_CNT_WIDTH-1:0] wdrop_cnt
);

    // Handshake: wren is a request, !wfull is the ready; a write moves only on
    // an edge where both hold, and wren while wfull is dropped and counted.
    logic [PTR_WIDTH-1:0]      r_wbin;
    logic [PTR_WIDTH-1:0]      r_wgray;
    logic                      r_full;
    logic                      r_afull;
    logic [PTR_WIDTH-1:0]      r_level;
    logic                      r_ovf;
    logic [DROP_CNT_WIDTH-1:0] r_drop;

    logic                      w_accept;
    logic                      w_reject;
    logic [PTR_WIDTH-1:0]      w_wbin_next;
    logic [PTR_WIDTH-1:0]      w_wgray_next;
    logic [PTR_WIDTH-1:0]      w_rbin_sync;
    logic [PTR_WIDTH-1:0]      w_level_next;
    logic [PTR_WIDTH-1:0]      w_full_match;
    logic                      w_full_next;

    gray2bin_conv #(
        .W (PTR_WIDTH)
    ) u_rptr_conv (
        .i_gray (rptr_sync2),
        .o_bin  (w_rbin_sync)
    );

    assign w_accept     = wren & ~r_full;
    assign w_reject     = wren & r_full;
    assign w_wbin_next  = r_wbin + PTR_WIDTH'(w_accept);
    assign w_wgray_next = PTR_WIDTH'(bin2gray(gvec_t'(w_wbin_next)));
    assign w_level_next = w_wbin_next - w_rbin_sync;

    // Full when the write pointer is exactly one lap ahead: Gray form of that
    // is the read pointer with its two MSBs inverted.
    assign w_full_match = {~rptr_sync2[PTR_WIDTH-1:PTR_WIDTH-2], rptr_sync2[PTR_WIDTH-3:0]};
    assign w_full_next  = (w_wgray_next == w_full_match);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wbin  <= '0;
            r_wgray <= '0;
            r_full  <= 1'b0;
            r_afull <= 1'b0;
            r_level <= '0;
        end else begin
            r_wbin  <= w_wbin_next;
            r_wgray <= w_wgray_next;
            r_full  <= w_full_next;
            r_afull <= (w_level_next >= af_thresh);
            r_level <= w_level_next;
        end
    end

    // A rejected write on the same edge as a clear wins over the clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (ovf_clr) begin
            r_ovf  <= w_reject;
            r_drop <= DROP_CNT_WIDTH'(w_reject);
        end else if (w_reject) begin
            r_ovf <= 1'b1;
            if (r_drop != {DROP_CNT_WIDTH{1'b1}}) begin
                r_drop <= r_drop + DROP_CNT_WIDTH'(1);
            end
        end
    end

    assign wrptr     = r_wgray;
    assign waddr     = r_wbin[ADDR_WIDTH-1:0];
    assign wfull     = r_full;
    assign wafull    = r_afull;
    assign wlevel    = r_level;
    assign woverflow = r_ovf;
    assign wdrop_cnt = r_drop;

endmodule

// File: tb/tb_wrptr_control_ext.sv
// Bench for wrptr_control_ext at ADDR_WIDTH=4: directed scenarios followed by
// random traffic, all checked against a word-count model of the FIFO.
module tb_wrptr_control_ext;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          wren;
    logic [PW-1:0] rptr_sync2;
    logic [PW-1:0] af_thresh;
    logic          ovf_clr;
    logic [PW-1:0] wrptr;
    logic [AW-1:0] waddr;
    logic          wfull;
    logic          wafull;
    logic [PW-1:0] wlevel;
    logic          woverflow;
    logic [DW-1:0] wdrop_cnt;

    int total = 0;
    int bad   = 0;

    // Model: counts of words written and words the read side has released.
    int m_wr;
    int m_rd;
    int m_level;
    bit m_full;
    bit m_afull;
    bit m_ovf;
    int m_drop;

    wrptr_control_ext #(
        .ADDR_WIDTH     (AW),
        .DROP_CNT_WIDTH (DW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wren       (wren),
        .rptr_sync2 (rptr_sync2),
        .af_thresh  (af_thresh),
        .ovf_clr    (ovf_clr),
        .wrptr      (wrptr),
        .waddr      (waddr),
        .wfull      (wfull),
        .wafull     (wafull),
        .wlevel     (wlevel),
        .woverflow  (woverflow),
        .wdrop_cnt  (wdrop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] gray_of(input int n);
        logic [PW-1:0] b;
        b = PW'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":wrptr"},     32'(wrptr),     32'(gray_of(m_wr)));
        chk({tag, ":waddr"},     32'(waddr),     32'(m_wr % DEPTH));
        chk({tag, ":wfull"},     32'(wfull),     32'(m_full));
        chk({tag, ":wafull"},    32'(wafull),    32'(m_afull));
        chk({tag, ":wlevel"},    32'(wlevel),    32'(m_level));
        chk({tag, ":woverflow"}, 32'(woverflow), 32'(m_ovf));
        chk({tag, ":wdrop_cnt"}, 32'(wdrop_cnt), 32'(m_drop));
    endtask

    task automatic model_reset();
        m_wr = 0; m_rd = 0; m_level = 0;
        m_full = 0; m_afull = 0; m_ovf = 0; m_drop = 0;
    endtask

    // Called just after a falling edge; drives inputs, takes one rising edge,
    // advances the model, then checks on the next falling edge.
    task automatic step(input string tag, input logic we, input logic clr);
        bit rej;
        wren       = we;
        ovf_clr    = clr;
        rptr_sync2 = gray_of(m_rd);
        @(posedge clk);
        rej = we && m_full;
        if (we && !m_full) m_wr++;
        m_level = m_wr - m_rd;
        m_full  = (m_level == DEPTH);
        m_afull = (m_level >= int'(af_thresh));
        if (rej) begin
            m_drop = clr ? 1 : ((m_drop == 255) ? 255 : m_drop + 1);
            m_ovf  = 1;
        end else if (clr) begin
            m_drop = 0;
            m_ovf  = 0;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        wren       = 1'b0;
        ovf_clr    = 1'b0;
        rptr_sync2 = '0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        af_thresh = PW'(12);
        do_reset();
        reset = 1'b1;
        @(negedge clk);
        check_all("reset");
        reset = 1'b0;

        // Fill from empty; almost-full rises on the edge producing level 12.
        for (int i = 1; i <= 16; i++) begin
            step("fill", 1'b1, 1'b0);
            if (i == 11) chk("af_below", 32'(wafull), 32'd0);
            if (i == 12) chk("af_rise", 32'(wafull), 32'd1);
            if (i == 15) begin
                chk("fill15_level", 32'(wlevel), 32'd15);
                chk("fill15_full", 32'(wfull), 32'd0);
            end
        end
        chk("fill_full", 32'(wfull), 32'd1);
        chk("fill_level", 32'(wlevel), 32'd16);
        chk("fill_wrptr", 32'(wrptr), 32'b11000);
        chk("fill_waddr", 32'(waddr), 32'd0);

        // Overflow, then clear colliding with another rejected write.
        repeat (3) step("ovf", 1'b1, 1'b0);
        chk("ovf_wrptr", 32'(wrptr), 32'b11000);
        chk("ovf_flag", 32'(woverflow), 32'd1);
        chk("ovf_cnt", 32'(wdrop_cnt), 32'd3);
        step("ovf_clr_set", 1'b1, 1'b1);
        chk("clr_set_cnt", 32'(wdrop_cnt), 32'd1);
        step("ovf_clr", 1'b0, 1'b1);
        chk("clr_flag", 32'(woverflow), 32'd0);

        // Drain visibility.
        m_rd = 3;
        step("drain", 1'b0, 1'b0);
        chk("drain_full", 32'(wfull), 32'd0);
        chk("drain_level", 32'(wlevel), 32'd13);
        chk("drain_waddr", 32'(waddr), 32'd0);
        step("drain_wr", 1'b1, 1'b0);
        chk("drain_wr_level", 32'(wlevel), 32'd14);
        chk("drain_wr_wrptr", 32'(wrptr), 32'b11001);

        // Almost-full fall as the reader advances.
        do_reset();
        for (int i = 0; i < 12; i++) step("af_fill", 1'b1, 1'b0);
        chk("af_at12", 32'(wafull), 32'd1);
        m_rd = 1;
        step("af_fall", 1'b0, 1'b0);
        chk("af_fall", 32'(wafull), 32'd0);
        chk("af_fall_level", 32'(wlevel), 32'd11);

        // Zero threshold is almost-full from the first edge after release.
        af_thresh = '0;
        do_reset();
        step("af_zero", 1'b0, 1'b0);
        chk("af_zero", 32'(wafull), 32'd1);

        // Wrap-around with a shallow level; threshold above depth never fires.
        af_thresh = PW'(20);
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (m_wr - m_rd >= 3) m_rd++;
            step("wrap", 1'b1, 1'b0);
            chk("wrap_nofull", 32'(wfull), 32'd0);
        end
        chk("wrap_count", 32'(m_wr), 32'd40);

        // Drop counter saturation.
        af_thresh = PW'(8);
        do_reset();
        for (int i = 0; i < 16; i++) step("sat_fill", 1'b1, 1'b0);
        for (int i = 0; i < 260; i++) step("sat", 1'b1, 1'b0);
        chk("sat_cnt", 32'(wdrop_cnt), 32'd255);

        // Asynchronous reset mid-operation at level 9 with overflow set.
        do_reset();
        for (int i = 0; i < 17; i++) step("mid_fill", 1'b1, 1'b0);
        m_rd = 7;
        step("mid_lvl", 1'b0, 1'b0);
        chk("mid_level", 32'(wlevel), 32'd9);
        chk("mid_ovf", 32'(woverflow), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        rptr_sync2 = '0;
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        chk("rst_waddr", 32'(waddr), 32'd0);
        step("post_rst", 1'b1, 1'b0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) af_thresh = PW'($urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0 && m_rd < m_wr)
                m_rd += $urandom_range(1, m_wr - m_rd);
            step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
